// File: rtl/ipml_prefetch_fifo_wr_if.sv
//-----------------------------------------------------------------------------
// ipml_prefetch_fifo_wr_if
//
// Purpose:
//   Write-side adapter between a valid/ready upstream stream and a FIFO write
//   port that signals "not full" on fifo_wr_vld. A 2-entry skid buffer
//   (head, tail) breaks every combinational path between the FIFO's
//   back-pressure and the upstream ready. This keeps one word per cycle
//   flowing while fifo_wr_vld stays high.
//
// Ports:
//   clk           rising-edge clock for all logic
//   rst_n         asynchronous active-low reset
//   in_valid      upstream word present
//   in_data       upstream word [DATA_W]
//   in_ready      block can take a word this cycle (state register decode)
//   fifo_wr_en    write request to FIFO (state register decode)
//   fifo_wr_data  write data to FIFO (head register) [DATA_W]
//   fifo_wr_vld   FIFO not full; a write commits when fifo_wr_en & fifo_wr_vld
//   wr_cnt        committed-write counter [CNT_W]
//
// Configuration:
//   IPML_WR_IF_CNT_EN  defined   -> wr_cnt counts commits, wrapping mod 2^CNT_W
//                      undefined -> wr_cnt tied to 0, no counter register
//-----------------------------------------------------------------------------
module ipml_prefetch_fifo_wr_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_vld,
    output logic [CNT_W-1:0]  wr_cnt
);

    // The encoding also gives the buffer occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;

    logic accept;
    logic commit;
    logic load_head;   // head <= in_data
    logic load_tail;   // tail <= in_data
    logic shift_tail;  // head <= tail

    // Both handshakes come from registered decodes, so neither in_ready nor
    // fifo_wr_en has a combinational path from the other side's inputs.
    assign in_ready     = (state != ST_TWO);
    assign fifo_wr_en   = (state != ST_EMPTY);
    assign fifo_wr_data = head;

    assign accept = in_valid & in_ready;
    assign commit = fifo_wr_en & fifo_wr_vld;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_head = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && commit) begin
                    // Head leaves and the new word replaces it, so
                    // fifo_wr_en stays high with no bubble.
                    load_head = 1'b1;
                end else if (accept) begin
                    load_tail = 1'b1;
                    state_nxt = ST_TWO;
                end else if (commit) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a commit can happen.
                if (commit) begin
                    shift_tail = 1'b1;
                    state_nxt  = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: the data registers have no reset. The state register alone says
    // which entries are live, so contents after reset are don't-care. Head
    // only changes on a load or a commit, which holds fifo_wr_data steady
    // while the FIFO stalls.
    always_ff @(posedge clk) begin
        if (load_head) begin
            head <= in_data;
        end else if (shift_tail) begin
            head <= tail;
        end
        if (load_tail) begin
            tail <= in_data;
        end
    end

`ifdef IPML_WR_IF_CNT_EN
    logic [CNT_W-1:0] cnt;

    // The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (commit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign wr_cnt = cnt;
`else
    assign wr_cnt = '0;
`endif

endmodule
